// File: rtl/spi_wb_bridge_if.sv
// Wishbone master-side bus bundle for spi_wb_bridge (pipelined WB, one outstanding cycle).
interface spi_wb_bridge_if #(
  parameter int unsigned WB_ADDR_WIDTH = 17,
  parameter int unsigned DATA_WIDTH    = 8
);
  logic [WB_ADDR_WIDTH-1:0] wb_addr_o;
  logic [DATA_WIDTH-1:0]    wb_data_o;
  logic [DATA_WIDTH-1:0]    wb_data_i;
  logic                     wb_we_o;
  logic                     wb_cycle_o;
  logic                     wb_strobe_o;
  logic                     wb_stall_i;
  logic                     wb_ack_i;

  modport master (
    output wb_addr_o, wb_data_o, wb_we_o, wb_cycle_o, wb_strobe_o,
    input  wb_data_i, wb_stall_i, wb_ack_i
  );

  modport slave (
    input  wb_addr_o, wb_data_o, wb_we_o, wb_cycle_o, wb_strobe_o,
    output wb_data_i, wb_stall_i, wb_ack_i
  );
endinterface

// File: rtl/spi_wb_bridge.sv
// SPI byte stream to Wishbone master bridge, system clock domain.
// Command byte + optional 3 address bytes, then auto-incrementing WB writes/reads.
// Optional macro SPI_WB_BRIDGE_TIMEOUT_EN: abort a WB cycle after 1023 cycles without ack.
module spi_wb_bridge #(
  parameter int unsigned WB_ADDR_WIDTH = 17,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                  wb_clock_i,
  input  logic                  wb_reset_ni,
  input  logic                  spi_cs_ni,
  input  logic                  spi_strobe_i,
  input  logic [DATA_WIDTH-1:0] spi_rx_i,
  output logic [DATA_WIDTH-1:0] spi_tx_o,
  output logic                  stall_o,
  output logic                  error_o,
  spi_wb_bridge_if.master       wb
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR2, S_ADDR1, S_ADDR0, S_WR_DATA, S_RD_ISSUE, S_RD_WAIT
  } state_e;

`ifdef SPI_WB_BRIDGE_TIMEOUT_EN
  localparam int unsigned TO_W = 10;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_hit;
`endif

  logic [1:0]               cs_sync_q, stb_sync_q;
  logic                     cs_prev_q, stb_prev_q;
  state_e                   state_q, state_d;
  logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    tx_q, tx_d;
  logic                     we_q, we_d, cyc_q, cyc_d, stb_q, stb_d;
  logic                     stall_q, stall_d, error_q, error_d;
  logic                     rd_op_q, rd_op_d, idle_pend_q, idle_pend_d;
  logic                     accept, cs_fall, cs_rise;

  // Edge detection on the synchronized SCK-domain signals.
  always_comb begin
    accept  = stb_sync_q[1] & ~stb_prev_q;
    cs_fall = cs_prev_q & ~cs_sync_q[1];
    cs_rise = ~cs_prev_q & cs_sync_q[1];
  end

  // Next-state: bus completion first, then the accepted byte, then CS transitions.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tx_d        = tx_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    stall_d     = stall_q;
    error_d     = error_q;
    rd_op_d     = rd_op_q;
    idle_pend_d = idle_pend_q;
`ifdef SPI_WB_BRIDGE_TIMEOUT_EN
    to_cnt_d    = cyc_q ? to_cnt_q + TO_W'(1) : '0;
    timeout_hit = cyc_q & ~wb.wb_ack_i & (to_cnt_q == '1);
`endif

    // A byte that needed no bus cycle holds stall for exactly one cycle.
    if (stall_q && !cyc_q) stall_d = 1'b0;

    if (cyc_q) begin
      if (stb_q && !wb.wb_stall_i) stb_d = 1'b0;
      if (wb.wb_ack_i) begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
        stall_d = 1'b0;
        addr_d  = addr_q + WB_ADDR_WIDTH'(1);
        if (state_q == S_RD_ISSUE) begin
          tx_d    = wb.wb_data_i;
          state_d = S_RD_WAIT;
        end
      end
`ifdef SPI_WB_BRIDGE_TIMEOUT_EN
      else if (timeout_hit) begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
        stall_d = 1'b0;
        error_d = 1'b1;
        if (state_q == S_RD_ISSUE) begin
          tx_d    = '1;
          state_d = S_RD_WAIT;
        end
      end
`endif
    end

    if (accept && state_q != S_IDLE) begin
      if (stall_q) begin
        error_d = 1'b1;
      end else begin
        stall_d = 1'b1;
        case (state_q)
          S_CMD: begin
            case (spi_rx_i[DATA_WIDTH-1 -: 2])
              2'b00:   begin rd_op_d = 1'b0; state_d = S_ADDR2; end
              2'b01:   begin rd_op_d = 1'b1; state_d = S_ADDR2; end
              2'b10:   state_d = S_WR_DATA;
              default: begin
                state_d = S_RD_ISSUE;
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                we_d    = 1'b0;
              end
            endcase
          end
          S_ADDR2: begin
            addr_d  = WB_ADDR_WIDTH'({addr_q, spi_rx_i});
            state_d = S_ADDR1;
          end
          S_ADDR1: begin
            addr_d  = WB_ADDR_WIDTH'({addr_q, spi_rx_i});
            state_d = S_ADDR0;
          end
          S_ADDR0: begin
            addr_d = WB_ADDR_WIDTH'({addr_q, spi_rx_i});
            if (rd_op_q) begin
              state_d = S_RD_ISSUE;
              cyc_d   = 1'b1;
              stb_d   = 1'b1;
              we_d    = 1'b0;
            end else begin
              state_d = S_WR_DATA;
            end
          end
          S_WR_DATA: begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b1;
            wdata_d = spi_rx_i;
          end
          S_RD_WAIT: begin
            state_d = S_RD_ISSUE;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b0;
          end
          default: ;
        endcase
      end
    end

    // CS deassert waits for any in-flight cycle; the address register is kept.
    if ((cs_rise || idle_pend_q) && !cyc_d) begin
      state_d     = S_IDLE;
      idle_pend_d = 1'b0;
    end else if (cs_rise) begin
      idle_pend_d = 1'b1;
    end

    if (cs_fall) begin
      state_d     = S_CMD;
      error_d     = 1'b0;
      idle_pend_d = 1'b0;
    end

    if (state_d != S_RD_ISSUE && state_d != S_RD_WAIT) tx_d = '0;
  end

  // State, synchronizers and registered outputs.
  always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      cs_sync_q   <= 2'b11;
      cs_prev_q   <= 1'b1;
      stb_sync_q  <= 2'b00;
      stb_prev_q  <= 1'b0;
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      tx_q        <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      stall_q     <= 1'b0;
      error_q     <= 1'b0;
      rd_op_q     <= 1'b0;
      idle_pend_q <= 1'b0;
`ifdef SPI_WB_BRIDGE_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      cs_sync_q   <= {cs_sync_q[0], spi_cs_ni};
      cs_prev_q   <= cs_sync_q[1];
      stb_sync_q  <= {stb_sync_q[0], spi_strobe_i};
      stb_prev_q  <= stb_sync_q[1];
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tx_q        <= tx_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      stall_q     <= stall_d;
      error_q     <= error_d;
      rd_op_q     <= rd_op_d;
      idle_pend_q <= idle_pend_d;
`ifdef SPI_WB_BRIDGE_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign wb.wb_addr_o   = addr_q;
  assign wb.wb_data_o   = wdata_q;
  assign wb.wb_we_o     = we_q;
  assign wb.wb_cycle_o  = cyc_q;
  assign wb.wb_strobe_o = stb_q;
  assign spi_tx_o       = tx_q;
  assign stall_o        = stall_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_spi_wb_bridge.sv
// Scoreboard bench for spi_wb_bridge: frame-level reference model, WB slave model,
// independent monitors for the WB bus and for spi_tx_o at each stall release.
`timescale 1ns/1ps
module tb_spi_wb_bridge;
  localparam int unsigned AW       = 17;
  localparam int unsigned DW       = 8;
  localparam int unsigned MEM_SIZE = 1 << AW;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_txn_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs_n = 1'b1;
  logic          strobe = 1'b0;
  logic [DW-1:0] rx = '0;
  logic [DW-1:0] tx;
  logic          stall, err;

  always #5 clk = ~clk;

  spi_wb_bridge_if #(.WB_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wbif ();

  spi_wb_bridge #(.WB_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .wb_clock_i  (clk),
    .wb_reset_ni (rst_n),
    .spi_cs_ni   (cs_n),
    .spi_strobe_i(strobe),
    .spi_rx_i    (rx),
    .spi_tx_o    (tx),
    .stall_o     (stall),
    .error_o     (err),
    .wb          (wbif.master)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]    model_mem [MEM_SIZE];
  logic [7:0]    slave_mem [MEM_SIZE];
  logic [AW-1:0] model_addr = '0;
  wb_txn_t       wb_q[$];
  logic [7:0]    tx_q[$];
  logic          mute = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-frame semantics of command, address and data bytes.
  task automatic model_frame(input bq_t fb);
    logic [1:0]    op;
    int            hdr;
    logic [AW-1:0] a;
    op = fb[0][7:6];
    if (op[1] == 1'b0) begin
      hdr = 4;
      model_addr = AW'({fb[1], fb[2], fb[3]});
    end else begin
      hdr = 1;
    end
    a = model_addr;
    for (int i = 0; i < fb.size(); i++) begin
      if (op[0] == 1'b0) begin
        if (i >= hdr) begin
          wb_q.push_back('{1'b1, a, fb[i]});
          model_mem[a] = fb[i];
          a = a + 1'b1;
        end
        tx_q.push_back(8'h00);
      end else begin
        if (i < hdr - 1) begin
          tx_q.push_back(8'h00);
        end else begin
          wb_q.push_back('{1'b0, a, 8'h00});
          tx_q.push_back(model_mem[a]);
          a = a + 1'b1;
        end
      end
    end
    model_addr = a;
  endtask

  // WB slave: random stall, ack 1..3 cycles after the strobe is taken.
  initial begin
    int            ack_cnt;
    logic          busy;
    logic [AW-1:0] ack_addr;
    ack_cnt = 0; busy = 1'b0; ack_addr = '0;
    wbif.wb_ack_i = 1'b0; wbif.wb_stall_i = 1'b0; wbif.wb_data_i = '0;
    forever begin
      @(negedge clk);
      wbif.wb_ack_i = 1'b0;
      if (!rst_n) begin
        busy = 1'b0; ack_cnt = 0;
      end else if (busy) begin
        if (ack_cnt > 0) ack_cnt--;
        if (ack_cnt == 0 && !mute) begin
          wbif.wb_ack_i  = 1'b1;
          wbif.wb_data_i = slave_mem[ack_addr];
          busy = 1'b0;
        end
      end else begin
        wbif.wb_stall_i = ($urandom_range(0, 3) == 0);
        if (wbif.wb_cycle_o && wbif.wb_strobe_o && !wbif.wb_stall_i) begin
          busy = 1'b1;
          ack_cnt = $urandom_range(1, 3);
          ack_addr = wbif.wb_addr_o;
          if (wbif.wb_we_o) slave_mem[wbif.wb_addr_o] = wbif.wb_data_o;
        end
      end
    end
  end

  // WB monitor: every accepted strobe is compared against the scoreboard.
  initial begin
    wb_txn_t e;
    forever begin
      @(negedge clk); #1;
      if (rst_n && wbif.wb_cycle_o && wbif.wb_strobe_o && !wbif.wb_stall_i) begin
        check("stall_during_wb_cycle", 32'(stall), 32'd1);
        if (wb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb_cycle: we=%0b addr=%0h with nothing expected", wbif.wb_we_o, wbif.wb_addr_o);
        end else begin
          e = wb_q.pop_front();
          check("wb_we", 32'(wbif.wb_we_o), 32'(e.we));
          check("wb_addr", 32'(wbif.wb_addr_o), 32'(e.addr));
          if (e.we) check("wb_wdata", 32'(wbif.wb_data_o), 32'(e.data));
        end
      end
      if (rst_n && wbif.wb_ack_i) check("cyc_high_at_ack", 32'(wbif.wb_cycle_o), 32'd1);
    end
  end

  // TX monitor: spi_tx_o is checked each time stall_o releases.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (prev && !stall) begin
          if (tx_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_stall_release: tx=%0h with nothing expected", tx);
          end else begin
            check("spi_tx", 32'(tx), 32'(tx_q.pop_front()));
          end
        end
        prev = stall;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_stall_low();
    int n;
    n = 0;
    while (stall && n < 300) begin @(negedge clk); n++; end
    check("stall_release", 32'(stall), 32'd0);
  endtask

  task automatic pulse(input logic [7:0] b);
    @(negedge clk);
    rx = b; strobe = 1'b1;
    repeat (2) @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    pulse(b);
    repeat (5) @(negedge clk);
    wait_stall_low();
  endtask

  task automatic run_frame(input bq_t fb);
    model_frame(fb);
    @(negedge clk); cs_n = 1'b0;
    repeat (4) @(negedge clk);
    foreach (fb[i]) send_byte(fb[i]);
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    check("no_error_in_frame", 32'(err), 32'd0);
  endtask

  task automatic wait_wb_drained();
    int n;
    n = 0;
    while (wb_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cyc"}, 32'(wbif.wb_cycle_o), 32'd0);
    check({tag, "_stb"}, 32'(wbif.wb_strobe_o), 32'd0);
    check({tag, "_we"}, 32'(wbif.wb_we_o), 32'd0);
    check({tag, "_addr"}, 32'(wbif.wb_addr_o), 32'd0);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_error"}, 32'(err), 32'd0);
    check({tag, "_tx"}, 32'(tx), 32'd0);
  endtask

  initial begin
    bq_t           fb;
    logic [1:0]    op;
    int            nd, n;
    logic [23:0]   ta;
    logic [7:0]    b;

    for (int i = 0; i < MEM_SIZE; i++) begin
      model_mem[i] = 8'($urandom);
      slave_mem[i] = model_mem[i];
    end
    model_mem[17'h1FFFF] = 8'h5A; slave_mem[17'h1FFFF] = 8'h5A;
    model_mem[17'h00000] = 8'hC3; slave_mem[17'h00000] = 8'hC3;

    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    fb = '{8'h00, 8'h00, 8'h12, 8'h34, 8'hAA, 8'hBB};
    run_frame(fb);
    fb = '{8'h80, 8'h77};
    run_frame(fb);
    fb = '{8'h40, 8'h01, 8'hFF, 8'hFF, 8'h11, 8'h22};
    run_frame(fb);

    for (int f = 0; f < 20; f++) begin
      fb = {};
      op = 2'($urandom);
      fb.push_back({op, 6'($urandom)});
      if (op[1] == 1'b0) for (int k = 0; k < 3; k++) fb.push_back(8'($urandom));
      nd = $urandom_range(1, 4);
      for (int k = 0; k < nd; k++) fb.push_back(8'($urandom));
      run_frame(fb);
    end

    // Overrun: second strobe arrives while the first write is still in flight.
    fb = '{8'h80, 8'h5C};
    model_frame(fb);
    @(negedge clk); cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h80);
    @(negedge clk); rx = 8'h5C; strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    @(negedge clk); strobe = 1'b1;
    @(negedge clk); strobe = 1'b0;
    repeat (6) @(negedge clk);
    wait_stall_low();
    repeat (4) @(negedge clk);
    check("overrun_sets_error", 32'(err), 32'd1);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    check("error_sticky_after_cs_rise", 32'(err), 32'd1);
    cs_n = 1'b0;
    repeat (5) @(negedge clk);
    check("error_cleared_on_cs_fall", 32'(err), 32'd0);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);

    // Read with no ack from the slave.
    ta = 24'($urandom);
    wb_q.push_back('{1'b0, AW'(ta), 8'h00});
    repeat (3) tx_q.push_back(8'h00);
`ifdef SPI_WB_BRIDGE_TIMEOUT_EN
    tx_q.push_back(8'hFF);
`endif
    mute = 1'b1;
    @(negedge clk); cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h40);
    send_byte(ta[23:16]);
    send_byte(ta[15:8]);
    pulse(ta[7:0]);
    n = 0;
    while (!wbif.wb_cycle_o && n < 20) begin @(negedge clk); n++; end
    check("noack_read_started", 32'(wbif.wb_cycle_o), 32'd1);
    n = 0;
    while (wbif.wb_cycle_o && n < 2100) begin @(negedge clk); n++; end
`ifdef SPI_WB_BRIDGE_TIMEOUT_EN
    check("timeout_cycle_count_in_range", 32'(n >= 1018 && n <= 1030), 32'd1);
    check("timeout_sets_error", 32'(err), 32'd1);
    repeat (4) @(negedge clk);
    check("timeout_tx_ff", 32'(tx), 32'hFF);
`else
    check("no_timeout_cyc_held", 32'(wbif.wb_cycle_o), 32'd1);
    check("no_timeout_stall_held", 32'(stall), 32'd1);
`endif
    @(negedge clk); #2;
    rst_n = 1'b0; cs_n = 1'b1; mute = 1'b0;
    #1 check_reset_outputs("reset_mid_read");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_addr = '0;
    repeat (3) @(negedge clk);

    // Write at the reset address, then reset while it is in flight.
    b = 8'($urandom);
    wb_q.push_back('{1'b1, AW'(0), b});
    tx_q.push_back(8'h00);
    mute = 1'b1;
    @(negedge clk); cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h80);
    pulse(b);
    n = 0;
    while (!wbif.wb_cycle_o && n < 20) begin @(negedge clk); n++; end
    wait_wb_drained();
    check("write_in_flight_cyc", 32'(wbif.wb_cycle_o), 32'd1);
    check("write_in_flight_we", 32'(wbif.wb_we_o), 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b0; cs_n = 1'b1; mute = 1'b0;
    #1 check_reset_outputs("reset_mid_write");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    check("wb_scoreboard_drained", 32'(wb_q.size()), 32'd0);
    check("tx_scoreboard_drained", 32'(tx_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_wb_bridge.md
Name: spi_wb_bridge

Overview:
- System-clock-domain controller that sequences the SCK-domain SPI byte engine and turns the received byte stream into Wishbone master transactions.
- Decodes a command byte and 3 address bytes, then streams data bytes as auto-incrementing WB writes or reads.
- Supplies the next transmit byte to the byte engine and exposes stall_o so the host MCU can pace bytes.
- Sits between the spi byte engine and the main WB interconnect (RAM/IO/VRAM).

Parameters:
- WB_ADDR_WIDTH, 17, WB address width; taken from the low bits of the 24-bit SPI address.
- DATA_WIDTH, 8, byte width; must match common_pkg DATA_WIDTH.

Ports:
- wb_clock_i  in  1  system clock; all logic in this domain.
- wb_reset_ni  in  1  asynchronous, active-low reset.
- spi_cs_ni  in  1  raw SPI chip select (SCK domain); synchronized internally.
- spi_strobe_i  in  1  byte-engine strobe_o (SCK domain); synchronized internally.
- spi_rx_i  in  DATA_WIDTH  byte-engine data_o; sampled only after the synchronized strobe rises.
- spi_tx_o  out  DATA_WIDTH  to byte-engine data_i; next byte to shift out.
- stall_o  out  1  to host GPIO; high while the bridge cannot accept the next byte.
- error_o  out  1  sticky error flag; cleared on each CS falling edge.
- wb_addr_o  out  WB_ADDR_WIDTH  WB address.
- wb_data_o  out  DATA_WIDTH  WB write data.
- wb_data_i  in  DATA_WIDTH  WB read data.
- wb_we_o  out  1  WB write enable.
- wb_cycle_o  out  1  WB CYC.
- wb_strobe_o  out  1  WB STB.
- wb_stall_i  in  1  WB STALL (pipelined).
- wb_ack_i  in  1  WB ACK.

Behaviour:
- Reset: state IDLE. All WB outputs = 0. spi_tx_o = 0. stall_o = 0. error_o = 0. Address register = 0.
- CDC:
  - spi_strobe_i and spi_cs_ni each pass through a 2-flop synchronizer.
  - A byte is accepted on the cycle the synchronized strobe rises, which is 3 clocks max after the raw strobe.
  - spi_rx_i is captured on that cycle; it is stable for at least 7 further SCK edges.
- Host pacing: after each byte the host waits at least 4 wb_clock_i periods, then waits for stall_o low before the first SCK of the next byte.
- stall_o goes high on the cycle after the accept. It stays high until the resulting WB cycle acks, or for 1 cycle if no WB cycle is needed.
- spi_tx_o is stable whenever stall_o is low.
- Command byte: cmd[7:6] selects the operation; cmd[5:0] is ignored.
  - 00 = WRITE: 3 address bytes follow.
  - 01 = READ: 3 address bytes follow.
  - 10 = WRITE_CONT: no address; uses the current address register.
  - 11 = READ_CONT: no address; uses the current address register.
- States: IDLE -> CMD -> ADDR2 -> ADDR1 -> ADDR0 -> {WR_DATA | RD_ISSUE}. _CONT commands go straight from CMD to WR_DATA or RD_ISSUE.
- Address bytes are MSB first (ADDR2 = addr[23:16]). The register keeps addr[WB_ADDR_WIDTH-1:0].
- WR_DATA: each accepted byte starts a WB write (cyc=stb=we=1, data = byte).
  - stb drops on the first cycle with wb_stall_i low.
  - cyc drops on ack.
  - The address increments on ack, then the state returns to WR_DATA.
- RD_ISSUE: starts a WB read at addr.
  - On ack, wb_data_i is loaded into spi_tx_o, the address increments, and the state goes to RD_WAIT.
  - In RD_WAIT, each accepted (dummy) byte triggers the next read.
- spi_tx_o = 0 in all states except read states.
- Address wrap: the address increments modulo 2^WB_ADDR_WIDTH (0x1FFFF -> 0x00000).
- Synchronized CS rising (deassert):
  - With no WB cycle in flight: go to IDLE next cycle.
  - With a WB cycle in flight: complete it (wait ack), then go to IDLE. The address register is retained for _CONT.
- Synchronized CS falling: clear error_o and enter CMD.
- Overrun: a byte accepted while stall_o is high is dropped and sets error_o.
- A strobe edge and a CS rise in the same cycle: the byte is processed first, then CS deassert is handled as above.
- No simultaneous WB cycles; at most one outstanding.

Optional Feature:
- Macro: SPI_WB_BRIDGE_TIMEOUT_EN.
- Defined: a 10-bit counter runs while wb_cycle_o is high.
  - When it reaches 1023 with no ack, it drops cyc/stb and sets error_o.
  - It does not increment the address.
  - A read timeout loads spi_tx_o with 8'hFF.
  - The state returns as if acked.
- Undefined: no counter; the bridge waits for ack indefinitely; error_o reports only overrun.

Test Plan:
- Reset mid-write (wb_reset_ni low while cyc=1) -> all WB outputs 0, stall_o=0, error_o=0 immediately (async).
- CS low, bytes 00,00,12,34,AA,BB -> WB writes 0x01234=AA, then 0x01235=BB. Each write has we=1 and cyc high until ack; stall_o high from accept until ack.
- Bytes 40,01,FF,FF,xx,xx with memory 0x1FFFF=5A, 0x00000=C3 -> spi_tx_o=5A after the address bytes, then C3 (address wrap). stall_o low only after each ack.
- After the previous write, new CS, bytes 80,77 -> write of 77 at 0x01236 (CONT uses the retained address).
- Second byte strobed 1 clock after the first, while stall_o is high -> byte dropped, no WB cycle, error_o=1. error_o clears on the next CS fall.
- TIMEOUT_EN defined, wb_ack_i held 0 on a READ -> cyc drops after 1023 cycles, error_o=1, spi_tx_o=FF. Undefined: cyc stays high for more than 2000 cycles.
